uart_rx_cfg: RTL and testbench

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit is decided by 3-sample majority vote. A 2-flop input synchroniser is included. Parity and framing errors are reported. Sits between the board RX pin and the command/FIFO logic, which consumes a one-cycle data-valid strobe.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 43 ++++
 rtl/uart_rx_cfg.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding, parity codes and helpers           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_sampler : 2-flop synchroniser, falling-edge detect, 3-sample vote |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic serial,
  input  logic sample_en,
  output logic rx_sync,
  output logic fall,
  output logic maj
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [1:0] samples;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      sync    <= 1'b1;
      prev    <= 1'b1;
      samples <= 2'b11;
    end else begin
      meta <= serial;
      sync <= meta;
      prev <= sync;
      if (sample_en) samples <= {samples[0], sync};
    end
  end

  // The two stored samples plus the live value form the three votes.
  assign rx_sync = sync;
  assign fall    = prev & ~sync;
  assign maj     = majority3(samples[1], samples[0], sync);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_cfg : configurable UART receiver (data bits, parity, stop bits)   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int               CNT_W   = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID     = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic             PAR_REQ = (PARITY == PARITY_ODD);

  generate
    if (CLOCKS_PER_BIT < 8 || CLOCKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_rx_cfg: CLOCKS_PER_BIT must be 8..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [3:0]           bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shadow, shadow_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 load;

  logic                 rx_sync;
  logic                 fall;
  logic                 maj;
  logic                 sampling;
  logic                 sample_en;
  logic [CNT_W-1:0]     target;
  logic                 at_target;

  uart_rx_sampler u_sampler (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .serial    (i_RX_Serial),
    .sample_en (sample_en),
    .rx_sync   (rx_sync),
    .fall      (fall),
    .maj       (maj)
  );

  // START decides mid-bit; every later bit is a full bit period away.
  assign target    = (state == ST_START) ? MID : LAST;
  assign at_target = (cnt == target);
  assign sampling  = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
  assign sample_en = sampling &&
                     ((cnt == target - CNT_W'(2)) || (cnt == target - CNT_W'(1)));
  assign o_Busy    = (state != ST_IDLE);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shadow       <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      shadow  <= shadow_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
      o_RX_DV <= load;
      if (load) begin
        o_RX_Byte    <= shadow_nxt;
        o_Parity_Err <= perr_nxt;
        o_Frame_Err  <= ferr_nxt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    idx_nxt    = bit_idx;
    shadow_nxt = shadow;
    perr_nxt   = perr;
    ferr_nxt   = ferr;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt  = '0;
        idx_nxt  = '0;
        perr_nxt = 1'b0;
        ferr_nxt = 1'b0;
        if (fall) state_nxt = ST_START;
      end
      ST_START: begin
        if (at_target) begin
          cnt_nxt   = '0;
          state_nxt = maj ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_target) begin
          cnt_nxt    = '0;
          shadow_nxt = {maj, shadow[DATA_BITS-1:1]};
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (at_target) begin
          cnt_nxt   = '0;
          perr_nxt  = ((^shadow) ^ maj) != PAR_REQ;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_target) begin
          cnt_nxt  = '0;
          ferr_nxt = ferr | ~maj;
          if (bit_idx == 4'(STOP_BITS - 1)) begin
            idx_nxt   = '0;
            load      = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ST_DONE: begin
        // Outputs were loaded on entry, so the strobe is visible during DONE.
        cnt_nxt   = '0;
        state_nxt = ferr ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rx_sync) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_cfg : scoreboard bench over 8N1, 8E1, 7O2 and 9N1 receivers    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_rx_cfg;

  localparam int CPB          = 16;
  localparam int FRAME_BUDGET = 14 * CPB;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1, rx_d = 1'b1;

  logic       dv_a, perr_a, ferr_a, busy_a;
  logic [7:0] byte_a;
  logic       dv_b, perr_b, ferr_b, busy_b;
  logic [7:0] byte_b;
  logic       dv_c, perr_c, ferr_c, busy_c;
  logic [6:0] byte_c;
  logic       dv_d, perr_d, ferr_d, busy_d;
  logic [8:0] byte_d;

  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_a), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
    .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Busy(busy_a));
  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_b), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
    .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Busy(busy_b));
  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut_c (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_c), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
    .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Busy(busy_c));
  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_dut_d (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_d), .o_RX_DV(dv_d), .o_RX_Byte(byte_d),
    .o_Parity_Err(perr_d), .o_Frame_Err(ferr_d), .o_Busy(busy_d));

  int n_a = 0, n_b = 0, n_c = 0, n_d = 0;
  always @(posedge clk) if (dv_a) n_a <= n_a + 1;
  always @(posedge clk) if (dv_b) n_b <= n_b + 1;
  always @(posedge clk) if (dv_c) n_c <= n_c + 1;
  always @(posedge clk) if (dv_d) n_d <= n_d + 1;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic dv_of(input int w);
    case (w)
      0:       return dv_a;
      1:       return dv_b;
      2:       return dv_c;
      default: return dv_d;
    endcase
  endfunction

  function automatic logic [8:0] byte_of(input int w);
    case (w)
      0:       return {1'b0, byte_a};
      1:       return {1'b0, byte_b};
      2:       return {2'b0, byte_c};
      default: return byte_d;
    endcase
  endfunction

  function automatic logic [1:0] flags_of(input int w);
    case (w)
      0:       return {perr_a, ferr_a};
      1:       return {perr_b, ferr_b};
      2:       return {perr_c, ferr_c};
      default: return {perr_d, ferr_d};
    endcase
  endfunction

  task automatic set_line(input int w, input logic v);
    case (w)
      0:       rx_a = v;
      1:       rx_b = v;
      2:       rx_c = v;
      default: rx_d = v;
    endcase
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and pushes its expected result; spike puts a one-cycle
  // high pulse into data bit 0 at the middle vote position.
  task automatic send_frame(input int w, input logic [8:0] data, input int nd,
                            input int pmode, input logic bad_par, input int nstop,
                            input logic [1:0] stops, input logic spike);
    logic       q[$];
    logic [8:0] dm;
    logic       pbit;
    logic       v;
    exp_t       e;
    dm = data & ((9'h1 << nd) - 9'h1);
    e.data = dm;
    e.perr = (pmode != 0) && bad_par;
    e.ferr = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nd; i++) q.push_back(dm[i]);
    if (pmode != 0) begin
      pbit = (pmode == 2) ? (^dm) : ~(^dm);
      q.push_back(pbit ^ bad_par);
    end
    for (int s = 0; s < nstop; s++) begin
      q.push_back(stops[s]);
      if (!stops[s]) e.ferr = 1'b1;
    end
    sb_q.push_back(e);
    for (int b = 0; b < q.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        v = q[b];
        if (spike && b == 1 && c == 7) v = 1'b1;
        set_line(w, v);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_frame(input int w, input string tag);
    exp_t       e;
    logic       seen;
    logic [1:0] fl;
    seen = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (dv_of(w)) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    total++;
    if (!seen) begin
      $display("FAIL %s strobe: got none within %0d cycles, required one", tag, FRAME_BUDGET);
      return;
    end
    passed++;
    fl = flags_of(w);
    total++;
    if (byte_of(w) !== e.data) $display("FAIL %s data: got %h required %h", tag, byte_of(w), e.data);
    else passed++;
    total++;
    if (fl[1] !== e.perr) $display("FAIL %s parity_err: got %b required %b", tag, fl[1], e.perr);
    else passed++;
    total++;
    if (fl[0] !== e.ferr) $display("FAIL %s frame_err: got %b required %b", tag, fl[0], e.ferr);
    else passed++;
    @(negedge clk);
    total++;
    if (dv_of(w) !== 1'b0) $display("FAIL %s dv_width: got %b required 0", tag, dv_of(w));
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    total++; if (dv_a !== 1'b0)     $display("FAIL reset_dv: got %b required 0", dv_a);     else passed++;
    total++; if (byte_a !== 8'h00)  $display("FAIL reset_byte: got %h required 00", byte_a); else passed++;
    total++; if (perr_a !== 1'b0)   $display("FAIL reset_perr: got %b required 0", perr_a); else passed++;
    total++; if (ferr_a !== 1'b0)   $display("FAIL reset_ferr: got %b required 0", ferr_a); else passed++;
    total++; if ({busy_a, busy_b, busy_c, busy_d} !== 4'b0000)
      $display("FAIL reset_busy: got %b required 0000", {busy_a, busy_b, busy_c, busy_d});
    else passed++;
    rst_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_8n1();
    int n0;
    n0 = n_a;
    fork
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 1'b0);
      wait_frame(0, "8n1_a5");
    join
    idle_cycles(2 * CPB);
    total++; if (n_a - n0 !== 1) $display("FAIL 8n1_count: got %0d required 1", n_a - n0); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL 8n1_busy: got %b required 0", busy_a); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int         n0;
    logic [9:0] bits;
    n0   = n_a;
    bits = {1'b1, 8'h81, 1'b0};
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rx_a = bits[b];
        idle_cycles(1);
      end
    end
    rx_a = bits[5];
    idle_cycles(7);
    total++; if (busy_a !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy_a); else passed++;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    @(negedge clk);
    total++; if (byte_a !== 8'h00) $display("FAIL midrst_byte: got %h required 00", byte_a); else passed++;
    total++; if ({dv_a, perr_a, ferr_a, busy_a} !== 4'b0000)
      $display("FAIL midrst_flags: got %b required 0000", {dv_a, perr_a, ferr_a, busy_a});
    else passed++;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(3 * CPB);
    total++; if (n_a !== n0) $display("FAIL midrst_no_strobe: got %0d strobes required 0", n_a - n0); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL midrst_idle: got %b required 0", busy_a); else passed++;
    fork
      send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11, 1'b0);
      wait_frame(0, "midrst_81");
    join
    idle_cycles(CPB);
  endtask

  task automatic test_glitch();
    int n0;
    n0   = n_a;
    rx_a = 1'b0;
    idle_cycles(4);
    rx_a = 1'b1;
    idle_cycles(3 * CPB);
    total++; if (n_a !== n0) $display("FAIL glitch_strobe: got %0d strobes required 0", n_a - n0); else passed++;
    total++; if (byte_a !== 8'h81) $display("FAIL glitch_byte: got %h required 81", byte_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL glitch_busy: got %b required 0", busy_a); else passed++;
    fork
      send_frame(0, 9'h000, 8, 0, 1'b0, 1, 2'b11, 1'b1);
      wait_frame(0, "spike_00");
    join
    idle_cycles(CPB);
  endtask

  task automatic test_parity();
    fork
      begin
        send_frame(1, 9'h003, 8, 2, 1'b1, 1, 2'b11, 1'b0);
        idle_cycles(CPB);
        send_frame(1, 9'h003, 8, 2, 1'b0, 1, 2'b11, 1'b0);
      end
      begin
        wait_frame(1, "8e1_bad");
        wait_frame(1, "8e1_good");
      end
    join
    idle_cycles(CPB);
  endtask

  task automatic test_frame_err();
    int n0;
    fork
      send_frame(2, 9'h055, 7, 1, 1'b0, 2, 2'b01, 1'b0);
      wait_frame(2, "7o2_ferr");
    join
    n0 = n_c;
    idle_cycles(40 * CPB);
    total++; if (n_c !== n0) $display("FAIL break_strobe: got %0d extra strobes required 0", n_c - n0); else passed++;
    total++; if (busy_c !== 1'b1) $display("FAIL break_busy: got %b required 1", busy_c); else passed++;
    rx_c = 1'b1;
    idle_cycles(2 * CPB);
    total++; if (busy_c !== 1'b0) $display("FAIL break_release: got %b required 0", busy_c); else passed++;
    fork
      send_frame(2, 9'h02A, 7, 1, 1'b0, 2, 2'b11, 1'b0);
      wait_frame(2, "7o2_2a");
    join
    idle_cycles(CPB);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_d;
    fork
      begin
        send_frame(3, 9'h1FF, 9, 0, 1'b0, 1, 2'b11, 1'b0);
        send_frame(3, 9'h000, 9, 0, 1'b0, 1, 2'b11, 1'b0);
        send_frame(3, 9'h155, 9, 0, 1'b0, 1, 2'b11, 1'b0);
      end
      begin
        wait_frame(3, "b2b_1ff");
        wait_frame(3, "b2b_000");
        wait_frame(3, "b2b_155");
      end
    join
    idle_cycles(2 * CPB);
    total++; if (n_d - n0 !== 3) $display("FAIL b2b_count: got %0d required 3", n_d - n0); else passed++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_reset_mid_frame();
    test_glitch();
    test_parity();
    test_frame_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
